gf_mul_ds_ctrl: RTL and testbench

Sequencing controller for the digit-serial GF(2^m) multiplier stage `serial`. It accepts one multiply request (a, b, g) through a valid/ready handshake and registers the operands. It then drives one instance of `serial`, feeding b most-significant-digit first, DIGITAL bits per clock, and accumulates the partial product. After NDIG digit cycles it presents a·b mod f(x) through an output valid/ready handshake. It is the top-level multiply engine used by the point-arithmetic layer.

---
 rtl/gf_mul_ds_ctrl.sv | 113 +++++++++++
 tb/tb_gf_mul_ds_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mul_ds_ctrl.sv
// Digit-serial GF(2^m) multiplier: one MSD-first digit step (serial) plus the
// request/run/result sequencer that drives it for NDIG cycles.

module serial #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DIGITAL-1:0]    b,
  input  logic [DATA_WIDTH-1:0] g,
  input  logic [DATA_WIDTH-1:0] t_i1_j1,
  output logic [DATA_WIDTH-1:0] t_i_j
);
  // Horner chain: per bit, t <- t*x mod f, then add a if that bit of b is set.
  logic [DATA_WIDTH-1:0] stage [DIGITAL+1];

  assign stage[0] = t_i1_j1;

  for (genvar gi = 0; gi < DIGITAL; gi++) begin : g_bit
    logic [DATA_WIDTH-1:0] times_x;
    assign times_x = {stage[gi][DATA_WIDTH-2:0], 1'b0}
                   ^ (g & {DATA_WIDTH{stage[gi][DATA_WIDTH-1]}});
    assign stage[gi+1] = times_x ^ (a & {DATA_WIDTH{b[DIGITAL-1-gi]}});
  end

  assign t_i_j = stage[DIGITAL];
endmodule

module gf_mul_ds_ctrl #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] g,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);
  localparam int NDIG  = (DATA_WIDTH + DIGITAL - 1) / DIGITAL;
  localparam int BW    = NDIG * DIGITAL;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] g_q;
  logic [BW-1:0]         b_sh_q;
  logic [DATA_WIDTH-1:0] t_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] t_d;

  serial #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIGITAL    (DIGITAL)
  ) u_serial (
    .a       (a_q),
    .b       (b_sh_q[BW-1 -: DIGITAL]),
    .g       (g_q),
    .t_i1_j1 (t_q),
    .t_i_j   (t_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      g_q     <= '0;
      b_sh_q  <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            g_q     <= g;
            b_sh_q  <= BW'(b);
            t_q     <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Zero padding digits sit at the top of b_sh and are consumed first.
          t_q    <= t_d;
          b_sh_q <= b_sh_q << DIGITAL;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NDIG - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = t_q;
endmodule

// File: tb/tb_gf_mul_ds_ctrl.sv
// Bench for gf_mul_ds_ctrl: default 163/8 instance plus a padded 5/2 instance,
// checked against a schoolbook multiply-then-reduce model.

module tb_gf_mul_ds_ctrl;
  localparam int M    = 163;
  localparam int NDIG = 21;
  localparam int MS   = 5;
  localparam int NDS  = 3;
  localparam logic [M-1:0] G163 = M'(8'hC9);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] a = '0, b = '0, g = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [M-1:0] result;
  logic         busy;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [MS-1:0] s_a = '0, s_b = '0, s_g = '0;
  logic          s_out_valid;
  logic          s_out_ready = 1'b1;
  logic [MS-1:0] s_result;
  logic          s_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf_mul_ds_ctrl #(.DATA_WIDTH(M), .DIGITAL(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .g(g), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  gf_mul_ds_ctrl #(.DATA_WIDTH(MS), .DIGITAL(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .g(s_g), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .busy(s_busy)
  );

  // Full polynomial product, then clear high terms using x^m = g.
  function automatic logic [M-1:0] gf_ref(input logic [M-1:0] fa, input logic [M-1:0] fb,
                                          input logic [M-1:0] fg, input int m);
    logic [2*M-1:0] p;
    p = '0;
    for (int i = 0; i < m; i++)
      if (fb[i]) p = p ^ ({{M{1'b0}}, fa} << i);
    for (int k = 2*m - 2; k >= m; k--)
      if (p[k]) begin
        p[k] = 1'b0;
        p = p ^ ({{M{1'b0}}, fg} << (k - m));
      end
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand163();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[M-1:0];
  endfunction

  task automatic run_op(input logic [M-1:0] ta, input logic [M-1:0] tbv, input logic [M-1:0] tg,
                        output logic [M-1:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    a = ta; b = tbv; g = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1; lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
    res = result;
    $display("txn a=%h b=%h g=%h result=%h lat=%0d", ta, tbv, tg, res, lat);
    if (out_ready && out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op_s(input logic [MS-1:0] ta, input logic [MS-1:0] tbv, input logic [MS-1:0] tg,
                          output logic [MS-1:0] res, output int lat);
    int w;
    w = 0;
    while (!s_in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    s_a = ta; s_b = tbv; s_g = tg; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1; lat++;
      if (s_out_valid) break;
    end
    if (!s_out_valid) lat = -1;
    res = s_result;
    $display("txn5 a=%h b=%h g=%h result=%h lat=%0d", ta, tbv, tg, res, lat);
    if (s_out_ready && s_out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL rst_result got %h want 0", result); end
    n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_in_ready got %b want 1", s_in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [M-1:0] res, ta, exp;
    int lat;
    run_op(M'(1), M'(1), G163, res, lat);
    n_vec++; if (res !== M'(1)) begin n_err++; $display("FAIL one_result got %h want 1", res); end
    n_vec++; if (lat != NDIG) begin n_err++; $display("FAIL one_latency got %0d want %0d", lat, NDIG); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL one_in_ready_after got %b want 1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL one_busy_after got %b want 0", busy); end

    run_op(M'(2), M'(1) << 162, G163, res, lat);
    n_vec++; if (res !== G163) begin n_err++; $display("FAIL x163_result got %h want %h", res, G163); end

    run_op(M'(3), M'(3), G163, res, lat);
    n_vec++; if (res !== M'(5)) begin n_err++; $display("FAIL three_sq got %h want 5", res); end

    ta = rand163();
    run_op(ta, '0, G163, res, lat);
    n_vec++; if (res !== '0) begin n_err++; $display("FAIL b_zero got %h want 0", res); end

    exp = gf_ref({M{1'b1}}, {M{1'b1}}, G163, M);
    run_op({M{1'b1}}, {M{1'b1}}, G163, res, lat);
    n_vec++; if (res !== exp) begin n_err++; $display("FAIL all_ones got %h want %h", res, exp); end
    n_vec++; if (lat != NDIG) begin n_err++; $display("FAIL all_ones_latency got %0d want %0d", lat, NDIG); end
  endtask

  task automatic test_backpressure();
    logic [M-1:0] res, ta, tbv, exp;
    int lat;
    ta = rand163(); tbv = rand163();
    exp = gf_ref(ta, tbv, G163, M);
    out_ready = 1'b0;
    run_op(ta, tbv, G163, res, lat);
    n_vec++; if (res !== exp) begin n_err++; $display("FAIL bp_result got %h want %h", res, exp); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = rand163(); b = rand163();
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, out_valid); end
      n_vec++; if (result !== exp) begin n_err++; $display("FAIL bp_hold_result cyc %0d got %h want %h", i, result, exp); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_not_taken busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    logic [M-1:0] res;
    int lat;
    a = rand163(); b = rand163(); g = G163; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrun_rst_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrun_rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_rst_busy got %b want 0", busy); end
    run_op(M'(1), M'(1), G163, res, lat);
    n_vec++; if (res !== M'(1)) begin n_err++; $display("FAIL post_rst_result got %h want 1", res); end
    n_vec++; if (lat != NDIG) begin n_err++; $display("FAIL post_rst_latency got %0d want %0d", lat, NDIG); end
  endtask

  task automatic test_small_width();
    logic [MS-1:0] res, ta, tbv, tg;
    logic [M-1:0]  exp;
    int lat;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin ta = 5'h12; tbv = 5'h0B; tg = 5'h05; end
      else begin ta = MS'($urandom); tbv = MS'($urandom); tg = MS'($urandom); end
      exp = gf_ref(M'(ta), M'(tbv), M'(tg), MS);
      run_op_s(ta, tbv, tg, res, lat);
      n_vec++; if (M'(res) !== exp) begin n_err++; $display("FAIL small_result %0d got %h want %h", i, res, exp[MS-1:0]); end
      n_vec++; if (lat != NDS) begin n_err++; $display("FAIL small_latency %0d got %0d want %0d", i, lat, NDS); end
    end
  endtask

  task automatic test_random();
    logic [M-1:0] res, ta, tbv, tg, exp;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ta = rand163(); tbv = rand163();
      tg = (i % 2 == 0) ? G163 : rand163();
      exp = gf_ref(ta, tbv, tg, M);
      run_op(ta, tbv, tg, res, lat);
      n_vec++; if (res !== exp) begin n_err++; $display("FAIL rand_result %0d got %h want %h", i, res, exp); end
      n_vec++; if (lat != NDIG) begin n_err++; $display("FAIL rand_latency %0d got %0d want %0d", i, lat, NDIG); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_small_width();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
